// File: rtl/pipe_exe_muldiv.sv
// EXE-stage iterative multiply/divide unit with private HI/LO registers.
// One result bit per cycle; busy stalls the front of the pipeline while in flight.
module pipe_exe_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    input  logic             wr_hi,
    input  logic             wr_lo,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned AW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic             busy_next;
    logic             done_next;
    logic [1:0]       op_q;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] opnd;
    logic [AW-1:0]    acc;
    logic [CW-1:0]    cnt;

    logic             idle_like_c;
    logic             accept_c;
    logic             div_zero_c;
    logic [WIDTH-1:0] a_abs_c;
    logic [WIDTH-1:0] b_abs_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   div_trial_c;
    logic [AW-1:0]    mul_next_c;
    logic [AW-1:0]    div_next_c;
    logic [AW-1:0]    acc_neg_c;
    logic [WIDTH-1:0] res_hi_c;
    logic [WIDTH-1:0] res_lo_c;

    // DONE is not busy, so a back-to-back start is taken there as well as in IDLE
    assign idle_like_c = (state == IDLE) || (state == DONE);
    assign accept_c    = start && idle_like_c;
    assign div_zero_c  = accept_c && op[1] && (eb == '0);

    // op[0]=1 selects the unsigned flavour; signed operands enter as magnitudes
    assign a_abs_c = (!op[0] && ea[WIDTH-1]) ? WIDTH'(-ea) : ea;
    assign b_abs_c = (!op[0] && eb[WIDTH-1]) ? WIDTH'(-eb) : eb;

    // Multiply: acc = {partial high, remaining multiplier bits}, shift right each step
    assign mul_sum_c  = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next_c = {mul_sum_c, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend bits / quotient bits}, shift left each step
    assign div_trial_c = acc[AW-1:WIDTH-1] - {1'b0, opnd};
    assign div_next_c  = div_trial_c[WIDTH] ? {acc[AW-2:0], 1'b0}
                                            : {div_trial_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign acc_neg_c = AW'(-acc);

    // Sign correction applied at write-back
    always_comb begin
        res_hi_c = acc[AW-1:WIDTH];
        res_lo_c = acc[WIDTH-1:0];
        if (!op_q[0]) begin
            if (!op_q[1]) begin
                if (sign_a ^ sign_b) begin
                    res_hi_c = acc_neg_c[AW-1:WIDTH];
                    res_lo_c = acc_neg_c[WIDTH-1:0];
                end
            end else begin
                if (sign_a ^ sign_b) begin
                    res_lo_c = WIDTH'(-acc[WIDTH-1:0]);
                end
                if (sign_a) begin
                    res_hi_c = WIDTH'(-acc[AW-1:WIDTH]);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept_c) begin
                    state_next = div_zero_c ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                if (cnt == LAST) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_next = 1'b0;
        done_next = 1'b0;
        case (state_next)
            CALC, FIX: busy_next = 1'b1;
            DONE:      done_next = 1'b1;
            default: ;
        endcase
    end

    // Datapath and architectural HI/LO; hi/lo only move on MTHI/MTLO or FIX
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            cnt    <= '0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (accept_c) begin
            op_q   <= op;
            sign_a <= ea[WIDTH-1];
            sign_b <= eb[WIDTH-1];
            opnd   <= op[1] ? b_abs_c : a_abs_c;
            acc    <= {WIDTH'(0), (op[1] ? a_abs_c : b_abs_c)};
            cnt    <= '0;
            dz     <= div_zero_c;
        end else if (idle_like_c) begin
            if (wr_hi) begin
                hi <= ea;
            end
            if (wr_lo) begin
                lo <= ea;
            end
        end else if (state == CALC) begin
            acc <= op_q[1] ? div_next_c : mul_next_c;
            cnt <= cnt + CW'(1);
        end else if (state == FIX) begin
            hi <= res_hi_c;
            lo <= res_lo_c;
        end
    end

endmodule

// File: tb/tb_pipe_exe_muldiv.sv
// Directed bench for pipe_exe_muldiv: hand-computed results, latency and control checks.
module tb_pipe_exe_muldiv;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        wr_hi;
    logic        wr_lo;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    pipe_exe_muldiv #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .ea    (ea),
        .eb    (eb),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present start for one edge; returns at the negedge of cycle N+1
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        ea    = a;
        eb    = b;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Advance until done (bounded); lat is the cycle index after the start edge
    task automatic wait_done(input int lat0, output int lat, output int busyc, output logic chg);
        logic [31:0] h0;
        logic [31:0] l0;
        h0    = hi;
        l0    = lo;
        lat   = lat0;
        busyc = 0;
        chg   = 1'b0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busyc++;
            if (hi !== h0 || lo !== l0) chg = 1'b1;
            @(negedge clock);
            lat++;
        end
    endtask

    initial begin
        int   lat;
        int   busyc;
        logic chg;
        int   pulses;

        reset = 1'b1;
        start = 1'b0;
        op    = MULT;
        ea    = '0;
        eb    = '0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dz",   32'(dz),   32'd0);
        chk("rst_hi",   hi,        32'd0);
        chk("rst_lo",   lo,        32'd0);
        reset = 1'b0;
        @(negedge clock);

        // MULT -3 * 5 = -15
        issue(MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(1, lat, busyc, chg);
        chk("mult_lat",   32'(lat),   32'd34);
        chk("mult_busyc", 32'(busyc), 32'd33);
        chk("mult_busy0", 32'(busy),  32'd0);
        chk("mult_hold",  32'(chg),   32'd0);
        chk("mult_hi",    hi,         32'hFFFF_FFFF);
        chk("mult_lo",    lo,         32'hFFFF_FFF1);
        @(negedge clock);
        chk("mult_pulse", 32'(done),  32'd0);

        // MULTU 0xFFFFFFFF * 2, then DIVU 100/7 started in the DONE cycle
        issue(MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_done(1, lat, busyc, chg);
        chk("multu_lat", 32'(lat), 32'd34);
        chk("multu_hi",  hi,       32'd1);
        chk("multu_lo",  lo,       32'hFFFF_FFFE);
        issue(DIVU, 32'd100, 32'd7);
        chk("b2b_busy",  32'(busy), 32'd1);
        wait_done(1, lat, busyc, chg);
        chk("divu_lat",  32'(lat), 32'd34);
        chk("divu_hi",   hi,       32'd2);
        chk("divu_lo",   lo,       32'd14);

        // DIV -7 / 2: quotient -3, remainder -1
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, lat, busyc, chg);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);

        // DIV 7 / -2: quotient -3, remainder +1
        issue(DIV, 32'd7, 32'hFFFF_FFFE);
        wait_done(1, lat, busyc, chg);
        chk("div_negb_lo", lo, 32'hFFFF_FFFD);
        chk("div_negb_hi", hi, 32'd1);

        // DIV most-negative by -1 wraps without a trap
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, lat, busyc, chg);
        chk("div_ovf_lo", lo,       32'h8000_0000);
        chk("div_ovf_hi", hi,       32'd0);
        chk("div_ovf_dz", 32'(dz),  32'd0);
        @(negedge clock);

        // MTHI
        ea    = 32'h1234_5678;
        wr_hi = 1'b1;
        @(negedge clock);
        wr_hi = 1'b0;
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_lo", lo, 32'h8000_0000);

        // DIVU by zero: done and dz in N+1, hi/lo untouched
        issue(DIVU, 32'd55, 32'd0);
        chk("dz_done", 32'(done), 32'd1);
        chk("dz_dz",   32'(dz),   32'd1);
        chk("dz_busy", 32'(busy), 32'd0);
        chk("dz_hi",   hi,        32'h1234_5678);
        chk("dz_lo",   lo,        32'h8000_0000);
        @(negedge clock);
        chk("dz_pulse", 32'(done), 32'd0);
        chk("dz_held",  32'(dz),   32'd1);
        chk("dz_busy2", 32'(busy), 32'd0);

        // MULT 7 * -6 clears dz on accept
        issue(MULT, 32'd7, 32'hFFFF_FFFA);
        chk("dz_clr",  32'(dz),   32'd0);
        chk("m2_busy", 32'(busy), 32'd1);
        wait_done(1, lat, busyc, chg);
        chk("m2_hi", hi, 32'hFFFF_FFFF);
        chk("m2_lo", lo, 32'hFFFF_FFD6);
        @(negedge clock);

        // start + wr_lo in CALC cycle 10 are both ignored
        issue(MULT, 32'h0001_0000, 32'h0001_0000);
        repeat (9) @(negedge clock);
        start = 1'b1;
        op    = DIVU;
        ea    = 32'd5;
        eb    = 32'd1;
        wr_lo = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wr_lo = 1'b0;
        wait_done(11, lat, busyc, chg);
        chk("ign_lat",  32'(lat), 32'd34);
        chk("ign_hold", 32'(chg), 32'd0);
        chk("ign_hi",   hi,       32'd1);
        chk("ign_lo",   lo,       32'd0);
        @(negedge clock);
        chk("ign_busy", 32'(busy), 32'd0);
        chk("ign_done", 32'(done), 32'd0);

        // Reset during DIVU CALC cycle 15
        issue(DIVU, 32'd1000, 32'd3);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_hi",   hi,        32'd0);
        chk("mid_rst_lo",   lo,        32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        chk("mid_rst_quiet", 32'(pulses), 32'd0);

        // MTHI and MTLO together
        ea    = 32'hCAFE_F00D;
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        @(negedge clock);
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        chk("mtboth_hi", hi, 32'hCAFE_F00D);
        chk("mtboth_lo", lo, 32'hCAFE_F00D);

        // Start coincident with MTHI: the write is dropped
        wr_hi = 1'b1;
        issue(MULTU, 32'd3, 32'd4);
        wr_hi = 1'b0;
        chk("sw_hi_kept", hi, 32'hCAFE_F00D);
        wait_done(1, lat, busyc, chg);
        chk("sw_hi", hi, 32'd0);
        chk("sw_lo", lo, 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_exe_muldiv.md
# pipe_exe_muldiv

Sequential multiply/divide unit for the EXE stage of the five-stage pipelined CPU. It consumes the operands and control latched by the ID/EXE pipeline register and computes MIPS-style MULT/MULTU/DIV/DIVU results into private HI/LO registers. It also services MTHI/MTLO writes. While an operation is in flight it raises a stall to the front of the pipeline.

## Interface
Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each; iteration count = WIDTH.

Ports:
- clock  in  1  rising-edge clock, sole clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin operation; sampled only when busy=0.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- ea  in  WIDTH  operand A (multiplicand / dividend; MTHI/MTLO data).
- eb  in  WIDTH  operand B (multiplier / divisor).
- wr_hi  in  1  MTHI: HI <= ea when busy=0 and start=0.
- wr_lo  in  1  MTLO: LO <= ea when busy=0 and start=0.
- busy  out  1  operation in progress; drives IF/ID stall.
- done  out  1  one-cycle pulse, result (or dz) valid.
- dz  out  1  last DIV/DIVU had divisor 0; held until next accepted start.
- hi  out  WIDTH  HI register (product high / remainder).
- lo  out  WIDTH  LO register (product low / quotient).

## Operation
- States: IDLE, CALC, FIX, DONE. busy = (state==CALC or FIX).
- IDLE/DONE + start: latch op, operand signs, and |ea|, |eb| (abs for signed ops, raw for unsigned). Clear dz. Counter <= 0. Go to CALC.
- Exception: a DIV/DIVU start with eb==0 goes directly to DONE, sets dz=1, and leaves hi/lo unchanged.
- CALC, multiply: radix-2 shift-add on a 2·WIDTH accumulator, one multiplier bit per cycle.
- CALC, divide: restoring shift-subtract, one quotient bit per cycle.
- CALC exit: counter increments each cycle; at counter==WIDTH-1, go to FIX.
- FIX, signed multiply: negate the 2·WIDTH product if the operand signs differ.
- FIX, signed divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend (truncation toward zero).
- FIX write-back: hi/lo take the corrected result at the FIX clock edge. Go to DONE.
- DONE: done=1 for exactly one cycle. Next state is CALC if start, else IDLE.
- DONE is not busy: a back-to-back start is accepted in DONE.
- start while busy: ignored. The upstream stall holds the instruction; it re-presents start after busy falls.
- wr_hi/wr_lo while busy: ignored. Coincident with an accepted start: start wins and the write is dropped.
- wr_hi and wr_lo together: both registers are written.
- DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0. No trap, dz=0.
- Arithmetic is modulo 2^WIDTH per register. Overflow is never flagged.

## Timing
- Reset (synchronous, clock edge with reset=1): state=IDLE, busy=0, done=0, dz=0, hi=0, lo=0, counter=0.
- Reset has priority over start and wr_*. Reset mid-operation discards the partial result.
- Start accepted at edge N: busy=1 in cycles N+1 … N+WIDTH+1 (CALC for WIDTH cycles, then FIX for 1 cycle).
- hi/lo hold their new values and done=1 in cycle N+WIDTH+2 (34 for WIDTH=32). busy=0 in that cycle.
- Divide-by-zero: done=1 and dz=1 in cycle N+1. busy never rises.
- MTHI/MTLO: the value appears on hi/lo the cycle after the write edge.
- hi/lo never change during CALC. Intermediate state is internal only.

## Test plan
- Reset, then MULT ea=0xFFFFFFFD (−3), eb=5 → 33 cycles busy; then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulse exactly 34 cycles after start.
- MULTU ea=0xFFFFFFFF, eb=2 → hi=0x00000001, lo=0xFFFFFFFE. Then immediately issue DIVU ea=100, eb=7 with start in the DONE cycle → accepted; hi=2, lo=14.
- DIV ea=0xFFFFFFF9 (−7), eb=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI ea=0x12345678 → hi=0x12345678. DIVU eb=0 → done and dz next cycle, busy stays 0, hi still 0x12345678. Next MULT clears dz.
- Start MULT, assert start (new op) and wr_lo at cycle 10 of CALC → both ignored; the original result is written unchanged.
- Start DIVU, assert reset at cycle 15 → next cycle state IDLE, hi=lo=0, busy=0, and no done pulse follows.
